// File: rtl/core_io_bridge.sv
// Bridge between the core's word-wide I/O port and a byte-wide UART transceiver.
// Output words are queued and sent LSB first; received bytes are queued and read back as words.
module core_io_bridge #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned OUT_DEPTH      = 8,
  parameter int unsigned IN_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          out_issued,
  input  logic [8*BYTES_PER_WORD-1:0]   out_data,
  output logic                          out_stall,
  input  logic                          in_issued,
  output logic [8*BYTES_PER_WORD-1:0]   in_data,
  output logic                          in_stall,
  output logic [31:0]                   status,
  output logic [31:0]                   result_bytes,
  input  logic                          status_clr,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid
);

  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
  localparam int unsigned OUT_CW = OUT_AW + 1;
  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned IN_CW  = IN_AW + 1;
  localparam int unsigned IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

  // ---------------- output FIFO ----------------
  logic [WORD_W-1:0] out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OUT_CW-1:0] out_count;
  logic              out_push, out_pop, out_empty;

  assign out_stall = (out_count == OUT_CW'(OUT_DEPTH));
  assign out_empty = (out_count == '0);
  assign out_push  = out_issued && !out_stall;

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr] <= out_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
      if (out_push && !out_pop)      out_count <= out_count + OUT_CW'(1);
      else if (!out_push && out_pop) out_count <= out_count - OUT_CW'(1);
    end
  end

  // ---------------- serialiser ----------------
  ser_state_e        state, state_d;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       result_q;
  logic              tx_hs, last_byte, ser_load, ser_adv;

  assign tx_valid     = (state == S_SHIFT);
  assign tx_data      = shreg[7:0];
  assign tx_hs        = tx_valid && tx_ready;
  assign last_byte    = (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign out_pop      = ser_load;
  assign result_bytes = result_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (!out_empty) state_d = S_SHIFT;
      S_SHIFT: if (tx_hs && last_byte && out_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Back-to-back reload on the last handshake keeps the byte stream gap-free.
  always_comb begin
    ser_load = 1'b0;
    ser_adv  = 1'b0;
    case (state)
      S_IDLE:  ser_load = !out_empty;
      S_SHIFT: begin
        if (tx_hs) begin
          if (last_byte) ser_load = !out_empty;
          else           ser_adv  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      idx      <= '0;
      result_q <= '0;
    end else begin
      if (ser_load) begin
        shreg <= out_mem[out_rd_ptr];
        idx   <= '0;
      end else if (ser_adv) begin
        shreg <= shreg >> 8;
        idx   <= idx + IDX_W'(1);
      end
      if (tx_hs) result_q <= result_q + 32'd1;
    end
  end

  // ---------------- input FIFO ----------------
  logic [7:0]        in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_ptr, in_rd_ptr;
  logic [IN_CW-1:0]  in_count;
  logic              in_full, in_push, in_pop, in_ovf, ovf_q;
  logic [WORD_W-1:0] in_word;
  logic [7:0]        in_cnt_sat;

  assign in_full  = (in_count == IN_CW'(IN_DEPTH));
  assign in_push  = rx_valid && !in_full;
  assign in_ovf   = rx_valid && in_full;
  assign in_stall = (in_count < IN_CW'(BYTES_PER_WORD));
  assign in_pop   = in_issued && !in_stall;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_AW'(BYTES_PER_WORD);
      in_count <= in_count + (in_push ? IN_CW'(1) : IN_CW'(0))
                           - (in_pop ? IN_CW'(BYTES_PER_WORD) : IN_CW'(0));
      // A new overflow beats a simultaneous clear.
      if (in_ovf)          ovf_q <= 1'b1;
      else if (status_clr) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    in_word = '0;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      in_word[8*i +: 8] = in_mem[in_rd_ptr + IN_AW'(i)];
    end
  end

  assign in_data    = in_stall ? '0 : in_word;
  assign in_cnt_sat = (32'(in_count) > 32'd255) ? 8'hFF : 8'(in_count);
  assign status     = {16'h0, in_cnt_sat, 4'h0, ovf_q, in_stall, out_stall,
                       out_empty && (state == S_IDLE)};

endmodule

// File: tb/tb_core_io_bridge.sv
// Directed self-checking bench for core_io_bridge: a default instance and a
// BYTES_PER_WORD=1 / OUT_DEPTH=2 instance share clock and reset.
module tb_core_io_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        out_issued = 0, in_issued = 0, status_clr = 0, tx_ready = 0, rx_valid = 0;
  logic [31:0] out_data = '0;
  logic [7:0]  rx_data = '0;
  logic        out_stall, in_stall, tx_valid;
  logic [31:0] in_data, status, result_bytes;
  logic [7:0]  tx_data;

  // narrow instance
  logic        u1_out_issued = 0, u1_in_issued = 0, u1_status_clr = 0, u1_tx_ready = 0, u1_rx_valid = 0;
  logic [7:0]  u1_out_data = '0, u1_rx_data = '0;
  logic        u1_out_stall, u1_in_stall, u1_tx_valid;
  logic [7:0]  u1_in_data, u1_tx_data;
  logic [31:0] u1_status, u1_result_bytes;

  core_io_bridge u0 (
    .clk(clk), .rst(rst),
    .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
    .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
    .status(status), .result_bytes(result_bytes), .status_clr(status_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  core_io_bridge #(.BYTES_PER_WORD(1), .OUT_DEPTH(2), .IN_DEPTH(16)) u1 (
    .clk(clk), .rst(rst),
    .out_issued(u1_out_issued), .out_data(u1_out_data), .out_stall(u1_out_stall),
    .in_issued(u1_in_issued), .in_data(u1_in_data), .in_stall(u1_in_stall),
    .status(u1_status), .result_bytes(u1_result_bytes), .status_clr(u1_status_clr),
    .tx_data(u1_tx_data), .tx_valid(u1_tx_valid), .tx_ready(u1_tx_ready),
    .rx_data(u1_rx_data), .rx_valid(u1_rx_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] w;

  initial begin
    // power-up reset
    tick(); tick();
    check("rst_status", status, 32'h5);
    check("rst_txv", {31'h0, tx_valid}, 32'h0);
    check("rst_txd", {24'h0, tx_data}, 32'h0);
    check("rst_in_data", in_data, 32'h0);
    check("rst_result", result_bytes, 32'h0);
    check("u1_rst_status", u1_status, 32'h5);
    rst = 1'b1;
    tick();

    // single word, first byte two cycles after issue
    tx_ready = 1; out_data = 32'h4433_2211; out_issued = 1;
    tick();
    out_issued = 0;
    check("lat_t1_txv", {31'h0, tx_valid}, 32'h0);
    tick();
    check("w_b0", {23'h0, tx_valid, tx_data}, 32'h111);
    tick();
    check("w_b1", {23'h0, tx_valid, tx_data}, 32'h122);
    tick();
    check("w_b2", {23'h0, tx_valid, tx_data}, 32'h133);
    tick();
    check("w_b3", {23'h0, tx_valid, tx_data}, 32'h144);
    tick();
    check("w_done_txv", {31'h0, tx_valid}, 32'h0);
    check("w_result", result_bytes, 32'd4);
    check("w_idle", {31'h0, status[0]}, 32'h1);

    // fill serialiser + FIFO under backpressure, then drain
    tx_ready = 0;
    for (int k = 0; k < 10; k++) begin
      w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      out_data = w; out_issued = 1;
      tick();
      if (k == 7) check("fill_stall8", {31'h0, out_stall}, 32'h0);
      if (k == 8) check("fill_stall9", {31'h0, out_stall}, 32'h1);
    end
    out_issued = 0;
    check("fill_stall10", {31'h0, out_stall}, 32'h1);
    check("fill_hold", {23'h0, tx_valid, tx_data}, 32'h101);
    tick();
    check("fill_hold2", {23'h0, tx_valid, tx_data}, 32'h101);
    tx_ready = 1;
    for (int b = 0; b < 36; b++) begin
      check($sformatf("drain_b%0d", b), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'(b+1)});
      tick();
    end
    check("drain_end_txv", {31'h0, tx_valid}, 32'h0);
    check("drain_result", result_bytes, 32'd40);
    check("drain_stall", {31'h0, out_stall}, 32'h0);

    // word assembly on input path
    rx_valid = 1; rx_data = 8'hAA; tick();
    rx_data = 8'hBB; tick();
    rx_data = 8'hCC; tick();
    rx_valid = 0;
    check("rx3_stall", {31'h0, in_stall}, 32'h1);
    check("rx3_count", {24'h0, status[15:8]}, 32'd3);
    rx_valid = 1; rx_data = 8'hDD; tick();
    rx_valid = 0;
    check("rx4_stall", {31'h0, in_stall}, 32'h0);
    check("rx4_data", in_data, 32'hDDCC_BBAA);
    in_issued = 1; tick();
    in_issued = 0;
    check("pop_stall", {31'h0, in_stall}, 32'h1);
    check("pop_count", {24'h0, status[15:8]}, 32'd0);
    in_issued = 1; tick();
    in_issued = 0;
    check("pop_ignored", {24'h0, status[15:8]}, 32'd0);

    // overflow: 17 bytes into 16 slots
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1; rx_data = 8'(i); tick();
    end
    rx_valid = 0;
    check("ovf_status", status, 32'h0000_1009);
    check("ovf_data", in_data, 32'h0302_0100);
    status_clr = 1; tick();
    status_clr = 0;
    check("ovf_clr", {31'h0, status[3]}, 32'h0);
    rx_valid = 1; rx_data = 8'hEE; in_issued = 1; tick();
    rx_valid = 0; in_issued = 0;
    check("full_pop_count", {24'h0, status[15:8]}, 32'd12);
    check("full_pop_ovf", {31'h0, status[3]}, 32'h1);
    check("full_pop_data", in_data, 32'h0706_0504);
    status_clr = 1; tick();
    status_clr = 0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_data = 8'hE0 + 8'(i); tick();
    end
    rx_valid = 1; rx_data = 8'h99; status_clr = 1; tick();
    rx_valid = 0; status_clr = 0;
    check("set_wins", {31'h0, status[3]}, 32'h1);
    check("set_wins_cnt", {24'h0, status[15:8]}, 32'd16);

    // asynchronous reset mid-transfer
    tx_ready = 0; out_data = 32'hCAFE_F00D; out_issued = 1; tick();
    out_issued = 0; tick();
    check("mid_txv_pre", {31'h0, tx_valid}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_txv", {31'h0, tx_valid}, 32'h0);
    check("mid_txd", {24'h0, tx_data}, 32'h0);
    check("mid_status", status, 32'h5);
    check("mid_result", result_bytes, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_txv", {31'h0, tx_valid}, 32'h0);

    // narrow instance
    u1_rx_valid = 1; u1_rx_data = 8'h3C; tick();
    u1_rx_valid = 0;
    check("u1_rx_stall", {31'h0, u1_in_stall}, 32'h0);
    check("u1_rx_data", {24'h0, u1_in_data}, 32'h3C);
    u1_in_issued = 1; tick();
    u1_in_issued = 0;
    check("u1_pop_stall", {31'h0, u1_in_stall}, 32'h1);
    u1_tx_ready = 1; u1_out_data = 8'h5A; u1_out_issued = 1; tick();
    u1_out_issued = 0; tick();
    check("u1_tx", {23'h0, u1_tx_valid, u1_tx_data}, 32'h15A);
    tick();
    check("u1_tx_end", {31'h0, u1_tx_valid}, 32'h0);
    check("u1_result", u1_result_bytes, 32'd1);
    force u1.result_q = 32'hFFFF_FFFF;
    #1 release u1.result_q;
    check("u1_preload", u1_result_bytes, 32'hFFFF_FFFF);
    @(negedge clk);
    u1_out_data = 8'h77; u1_out_issued = 1; tick();
    u1_out_issued = 0; tick();
    check("u1_tx2", {23'h0, u1_tx_valid, u1_tx_data}, 32'h177);
    tick();
    check("u1_wrap", u1_result_bytes, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
